cpu_exec_ctrl: RTL

Execution sequencer for the PIC10-compatible CPU. It drives the ALU's opcode, W and operand inputs and the carry-in, and consumes the ALU's result, status flags and load enables. It runs the four-phase (Q1–Q4) instruction cycle and owns the instruction register, W register and STATUS register. It performs write-back to W or the file register bank, and turns ALU test results into next-instruction skips.

---
 rtl/cpu_exec_ctrl_pkg.sv | 43 ++++
 rtl/cpu_exec_ctrl_if.sv | 36 +++
 rtl/cpu_wb_decode.sv | 47 ++++
 rtl/cpu_exec_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared definitions for the PIC10-style execution sequencer:
// phase encoding, STATUS bit positions, opcode match constants, decode record.
package cpu_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    SKIP_NONE  = 2'd0,
    SKIP_ON_Z  = 2'd1,
    SKIP_ON_NZ = 2'd2
  } skip_t;

  localparam int STATUS_C  = 0;
  localparam int STATUS_DC = 1;
  localparam int STATUS_Z  = 2;

  localparam logic [11:0] OP_NOP     = 12'h000;
  localparam logic [11:0] OP_OPTION  = 12'h002;
  localparam logic [11:0] OP_TRIS_LO = 12'h005;
  localparam logic [11:0] OP_TRIS_HI = 12'h007;
  localparam logic [5:0]  OP_DECFSZ  = 6'b001011;
  localparam logic [5:0]  OP_INCFSZ  = 6'b001111;
  localparam logic [1:0]  OP_BCF     = 2'b00;
  localparam logic [1:0]  OP_BSF     = 2'b01;
  localparam logic [1:0]  OP_BTFSC   = 2'b10;
  localparam logic [1:0]  OP_BTFSS   = 2'b11;
  localparam logic [1:0]  OP_RETLW   = 2'b00;

  typedef struct packed {
    logic  w_we;
    logic  f_we;
    logic  option_we;
    logic  tris_we;
    skip_t skip_test;
    logic  flush;
  } wb_ctl_t;

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// ALU, file bank and program-memory side signals of the execution sequencer.
interface cpu_exec_ctrl_if;
  logic [11:0] instr_in;
  logic [7:0]  alu_out;
  logic [2:0]  alu_status_out;
  logic        status_c_load;
  logic        status_dc_load;
  logic        status_z_load;
  logic [7:0]  file_rdata;
  logic [11:0] alu_op_out;
  logic [7:0]  alu_w_out;
  logic [7:0]  alu_mux_out;
  logic        status_carry_out;
  logic [7:0]  status_out;
  logic [4:0]  file_addr;
  logic [7:0]  file_wdata;
  logic        file_we;
  logic        option_we;
  logic        tris_we;
  logic        pc_inc;
  logic [1:0]  phase;

  modport master (
    input  instr_in, alu_out, alu_status_out, status_c_load, status_dc_load,
           status_z_load, file_rdata,
    output alu_op_out, alu_w_out, alu_mux_out, status_carry_out, status_out,
           file_addr, file_wdata, file_we, option_we, tris_we, pc_inc, phase
  );

  modport slave (
    output instr_in, alu_out, alu_status_out, status_c_load, status_dc_load,
           status_z_load, file_rdata,
    input  alu_op_out, alu_w_out, alu_mux_out, status_carry_out, status_out,
           file_addr, file_wdata, file_we, option_we, tris_we, pc_inc, phase
  );
endinterface

// File: rtl/cpu_wb_decode.sv
// Combinational decode of the instruction register into write-back
// destinations, special-register strobes and skip/flush behaviour.
module cpu_wb_decode
  import cpu_exec_ctrl_pkg::*;
(
  input  logic [11:0] ir,
  output wb_ctl_t     ctl
);

  always_comb begin
    ctl           = '0;
    ctl.skip_test = SKIP_NONE;
    case (ir[11:10])
      2'b00: begin
        if (ir[11:6] == 6'b000000) begin
          // MOVWF has bit 5 set; the rest of this row are NOP/OPTION/TRIS/SLEEP/CLRWDT
          if (ir[5]) begin
            ctl.f_we = 1'b1;
          end else begin
            ctl.option_we = (ir == OP_OPTION);
            ctl.tris_we   = (ir >= OP_TRIS_LO) && (ir <= OP_TRIS_HI);
          end
        end else begin
          // CLRW/CLRF follow the same d-bit rule as the other byte ops
          ctl.f_we = ir[5];
          ctl.w_we = ~ir[5];
          if ((ir[11:6] == OP_DECFSZ) || (ir[11:6] == OP_INCFSZ))
            ctl.skip_test = SKIP_ON_Z;
        end
      end
      2'b01: begin
        case (ir[9:8])
          OP_BCF, OP_BSF: ctl.f_we      = 1'b1;
          OP_BTFSC:       ctl.skip_test = SKIP_ON_Z;
          OP_BTFSS:       ctl.skip_test = SKIP_ON_NZ;
          default:        ctl.f_we      = 1'b0;
        endcase
      end
      2'b10: begin
        ctl.flush = 1'b1;
        ctl.w_we  = (ir[9:8] == OP_RETLW);
      end
      default: ctl.w_we = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Four-phase instruction sequencer: owns IR, W and STATUS, commits write-back
// in Q4 and replaces the next fetch with a NOP on skip or flush.
//   state | meaning
//   Q1    | decode
//   Q2    | operand settles on alu_mux_out
//   Q3    | ALU result settles; skip condition latched on exit
//   Q4    | write-back, strobes and fetch on exit
module cpu_exec_ctrl
  import cpu_exec_ctrl_pkg::*;
#(
  parameter logic [4:0] STATUS_ADDR  = 5'h03,
  parameter logic [7:0] STATUS_RESET = 8'h18
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  cpu_exec_ctrl_if.master    bus
);

  phase_t      state;
  phase_t      state_nxt;
  logic [11:0] ir;
  logic [7:0]  w_reg;
  logic [7:0]  status;
  logic [7:0]  status_nxt;
  logic        skip_flag;
  logic        skip_now;
  logic        commit;
  logic        status_hit;
  wb_ctl_t     ctl;

  cpu_wb_decode u_wb_decode (
    .ir  (ir),
    .ctl (ctl)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= Q1;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (run) begin
      case (state)
        Q1:      state_nxt = Q2;
        Q2:      state_nxt = Q3;
        Q3:      state_nxt = Q4;
        default: state_nxt = Q1;
      endcase
    end
  end

  assign commit     = run && (state == Q4);
  assign status_hit = (ir[4:0] == STATUS_ADDR);

  always_comb begin
    skip_now = ctl.flush;
    case (ctl.skip_test)
      SKIP_ON_Z:  skip_now = ctl.flush |  bus.alu_status_out[STATUS_Z];
      SKIP_ON_NZ: skip_now = ctl.flush | ~bus.alu_status_out[STATUS_Z];
      default:    skip_now = ctl.flush;
    endcase
  end

  // Flag loads are applied after the byte write so they override it
  always_comb begin
    status_nxt = status;
    if (commit) begin
      if (ctl.f_we && status_hit)  status_nxt = bus.alu_out;
      if (bus.status_c_load)       status_nxt[STATUS_C]  = bus.alu_status_out[STATUS_C];
      if (bus.status_dc_load)      status_nxt[STATUS_DC] = bus.alu_status_out[STATUS_DC];
      if (bus.status_z_load)       status_nxt[STATUS_Z]  = bus.alu_status_out[STATUS_Z];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir        <= OP_NOP;
      w_reg     <= 8'h00;
      status    <= STATUS_RESET;
      skip_flag <= 1'b0;
    end else begin
      status <= status_nxt;
      if (run && (state == Q3)) skip_flag <= skip_now;
      if (commit) begin
        if (ctl.w_we) w_reg <= bus.alu_out;
        ir        <= skip_flag ? OP_NOP : bus.instr_in;
        skip_flag <= 1'b0;
      end
    end
  end

  assign bus.alu_op_out       = ir;
  assign bus.alu_w_out        = w_reg;
  assign bus.status_out       = status;
  assign bus.status_carry_out = status[STATUS_C];
  assign bus.file_addr        = ir[4:0];
  assign bus.file_wdata       = bus.alu_out;
  assign bus.alu_mux_out      = status_hit ? status : bus.file_rdata;
  assign bus.file_we          = commit && ctl.f_we && !status_hit;
  assign bus.option_we        = commit && ctl.option_we;
  assign bus.tris_we          = commit && ctl.tris_we;
  assign bus.pc_inc           = commit;
  assign bus.phase            = state;

endmodule
